// File: rtl/pmem_arbiter.sv
// Two-master arbiter (instruction fetch and load/store) in front of a single
// physical-memory port. One request is outstanding at a time; conflicts are
// resolved by alternating between the two masters.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction-fetch port
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  // load/store port
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_wen_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  // physical-memory port
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_grant_q, last_grant_d;

  logic                    mem_req_valid_q, mem_req_valid_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;

  logic                    ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                    lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_WIDTH-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_WIDTH-1:0]   lsu_rdata_q, lsu_rdata_d;

  logic                    grant_ifu;
  logic                    grant_lsu;

  // Pick at most one valid requester while idle; on conflict the master that
  // did not win last time goes first.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE) begin
      if (ifu_req_valid_i && lsu_req_valid_i) begin
        if (last_grant_q == OWN_LSU) begin
          grant_ifu = 1'b1;
        end else begin
          grant_lsu = 1'b1;
        end
      end else begin
        grant_ifu = ifu_req_valid_i;
        grant_lsu = lsu_req_valid_i;
      end
    end
  end

  assign ifu_req_ready_o = grant_ifu;
  assign lsu_req_ready_o = grant_lsu;

  // Next-state and registered-output computation for the transaction FSM.
  // mem_req_valid/mem_wen are computed from the next state so that they are
  // plain flops that are high exactly while the FSM sits in REQ.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_wen_d       = mem_wen_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    ifu_rsp_valid_d = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rdata_d     = lsu_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_ifu) begin
          addr_d          = ifu_addr_i;
          wdata_d         = '0;
          wmask_d         = '0;
          mem_wen_d       = 1'b0;
          owner_d         = OWN_IFU;
          last_grant_d    = OWN_IFU;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end else if (grant_lsu) begin
          addr_d          = lsu_addr_i;
          wdata_d         = lsu_wdata_i;
          wmask_d         = lsu_wmask_i;
          mem_wen_d       = lsu_wen_i;
          owner_d         = OWN_LSU;
          last_grant_d    = OWN_LSU;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end
      end

      S_REQ: begin
        // A response strobe arriving here (even with ready) is not ours yet.
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          mem_wen_d       = 1'b0;
          state_d         = S_WAIT_RSP;
        end
      end

      S_WAIT_RSP: begin
        if (mem_rsp_valid_i) begin
          if (owner_q == OWN_IFU) begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = mem_rdata_i;
          end else begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = mem_rdata_i;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        mem_req_valid_d = 1'b0;
        mem_wen_d       = 1'b0;
        state_d         = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IFU;
      last_grant_q    <= OWN_LSU;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_wen_q       <= mem_wen_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      lsu_rdata_q     <= lsu_rdata_d;
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_wen_o       = mem_wen_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;

  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign ifu_rdata_o     = ifu_rdata_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign lsu_rdata_o     = lsu_rdata_q;

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be: default 32, byte address width.
REQ-002 Parameter DATA_WIDTH SHALL be: default 32, word width; a multiple of 8.
REQ-003 Port list SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid_i  in  1  instruction-fetch read request.
- ifu_req_ready_o  out  1  IFU request accepted this cycle.
- ifu_addr_i  in  ADDR_WIDTH  fetch address.
- ifu_rsp_valid_o  out  1  one-cycle IFU response strobe.
- ifu_rdata_o  out  DATA_WIDTH  fetched instruction.
- lsu_req_valid_i  in  1  load/store request.
- lsu_req_ready_o  out  1  LSU request accepted this cycle.
- lsu_addr_i  in  ADDR_WIDTH  data address.
- lsu_wen_i  in  1  1 = store, 0 = load.
- lsu_wdata_i  in  DATA_WIDTH  store data.
- lsu_wmask_i  in  DATA_WIDTH/8  byte-enable mask for stores.
- lsu_rsp_valid_o  out  1  one-cycle LSU response strobe.
- lsu_rdata_o  out  DATA_WIDTH  load data.
- mem_req_valid_o  out  1  request to pmem.
- mem_req_ready_i  in  1  pmem accepts request.
- mem_addr_o  out  ADDR_WIDTH  pmem address.
- mem_wen_o  out  1  pmem write enable.
- mem_wdata_o  out  DATA_WIDTH  pmem write data.
- mem_wmask_o  out  DATA_WIDTH/8  pmem byte mask.
- mem_rsp_valid_i  in  1  pmem response strobe (reads and writes).
- mem_rdata_i  in  DATA_WIDTH  pmem read data.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, REQ and WAIT_RSP. An owner register (IFU/LSU) and a last_grant register SHALL accompany it.
REQ-005 In IDLE, the arbiter SHALL assert the ready of exactly one valid requester, combinationally.
- Only one requester valid: that requester wins.
- Both valid: the requester not equal to last_grant wins.
REQ-006 On accept (valid & ready), the arbiter SHALL take the following actions and move to REQ:
- latch addr, wen, wdata and wmask; IFU forces wen=0 and wmask=0;
- set owner and last_grant to the winner.
REQ-007 The ready outputs SHALL be 0 in REQ and WAIT_RSP; at most one request is outstanding.
REQ-008 In REQ, mem_req_valid_o SHALL be 1 and mem_* SHALL hold the latched fields stable. On mem_req_ready_i the FSM SHALL move to WAIT_RSP.
REQ-009 Outside REQ, mem_req_valid_o SHALL be 0 and mem_wen_o SHALL be 0.
REQ-010 In WAIT_RSP, on mem_rsp_valid_i the arbiter SHALL take the following actions and return to IDLE:
- register mem_rdata_i into the owner's rdata_o;
- pulse the owner's rsp_valid_o for exactly one cycle, in the following cycle.
REQ-011 Both rdata_o SHALL hold their last value until the next response to that requester.
REQ-012 A store SHALL still complete via mem_rsp_valid_i, and lsu_rsp_valid_o SHALL pulse for it. lsu_rdata_o SHALL be updated with mem_rdata_i (content don't-care).
REQ-013 mem_rsp_valid_i SHALL be ignored in IDLE and REQ, including in the same cycle as mem_req_ready_i.
REQ-014 Latency SHALL be as follows, given accept at cycle T, mem_req_ready_i at T+1 and mem_rsp_valid_i at T+2:
- rsp_valid_o asserts at T+3;
- the next accept is possible at T+3 (the FSM is IDLE in that cycle).
REQ-015 Requesters withdrawing valid before being accepted SHALL cause no memory access.
REQ-016 A requester that is continuously valid SHALL be granted within 2 arbitration rounds (no starvation).

Reset
REQ-017 While rst_n=0, regardless of clk, the arbiter SHALL hold the following values:
- state = IDLE; owner = IFU;
- last_grant = LSU, so IFU wins the first conflict;
- all rsp_valid_o = 0, all rdata_o = 0;
- mem_req_valid_o = 0 and all mem_* = 0.
REQ-018 Reset asserted in REQ or WAIT_RSP SHALL drop the transaction. A later stray mem_rsp_valid_i SHALL then be ignored, per REQ-013.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single fetch: IFU addr 0x80000000, mem ready immediately, rdata 0x00000413 one cycle later -> ifu_rsp_valid_o pulse at T+3, ifu_rdata_o=0x00000413, lsu_rsp_valid_o stays 0.
- Conflict after reset: both valid at the same cycle -> IFU granted first, LSU granted in the first IDLE after the IFU response.
- Store: LSU wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_* carry those values, stable through 3 cycles of mem_req_ready_i=0; lsu_rsp_valid_o pulses once.
- Back-pressure with stray response: mem_req_ready_i held 0 for 5 cycles with mem_rsp_valid_i pulsed in REQ -> no response strobe; the transaction completes normally afterwards.
- Reset mid-transaction: rst_n low in WAIT_RSP, then mem_rsp_valid_i -> all outputs at reset values, no rsp_valid pulse.
- Fairness: both requesters continuously valid for 8 transactions -> grants alternate IFU, LSU, IFU, ...
